puf_sequencer: RTL

PUF_SEQUENCER -- requirements
Module: puf_sequencer

---
 rtl/puf_sequencer.sv | 116 +++++++++++
 1 files changed

// File: rtl/puf_sequencer.sv
// Arbiter-PUF key sequencer: fires each of 8 LFSR challenges VOTES times and majority-votes the response into key/stable.
// Latency: 8*(SETTLE + VOTES*(HOLD+SETTLE) + 1) cycles from accepted start to the one-cycle done strobe.
// Backpressure: none; start is only sampled in IDLE and is ignored while busy.
module puf_sequencer #(
    parameter int SETTLE = 4,
    parameter int HOLD   = 4,
    parameter int VOTES  = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] seed,
    output logic [7:0] puf_challenge,
    output logic       puf_pulse,
    input  logic       puf_response,
    output logic       busy,
    output logic       done,
    output logic [7:0] key,
    output logic [7:0] stable
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_APPLY   = 3'd1;
    localparam logic [2:0] S_FIRE    = 3'd2;
    localparam logic [2:0] S_RELAX   = 3'd3;
    localparam logic [2:0] S_RESOLVE = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [7:0] cnt;
    logic [7:0] lfsr;
    logic [7:0] lfsr_nxt;
    logic [2:0] bit_idx;
    logic [3:0] vote_cnt;
    logic [3:0] ones;
    logic       fire_last;
    logic       chal_on_nxt;

    assign fire_last = (state == S_FIRE) && (cnt == 8'(HOLD - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = S_APPLY;
            S_APPLY:   if (cnt == 8'(SETTLE - 1)) state_nxt = S_FIRE;
            S_FIRE:    if (fire_last) state_nxt = S_RELAX;
            S_RELAX:   if (cnt == 8'(SETTLE - 1))
                           state_nxt = (vote_cnt < 4'(VOTES)) ? S_FIRE : S_RESOLVE;
            S_RESOLVE: state_nxt = (bit_idx == 3'd7) ? S_DONE : S_APPLY;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Value the LFSR will hold next cycle, so the registered challenge lines up with it.
    always_comb begin
        lfsr_nxt = lfsr;
        if (state == S_IDLE && start)
            lfsr_nxt = (seed == 8'h00) ? 8'h01 : seed;
        else if (state == S_RESOLVE)
            lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign chal_on_nxt = (state_nxt == S_APPLY) || (state_nxt == S_FIRE) ||
                         (state_nxt == S_RELAX) || (state_nxt == S_RESOLVE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= 8'h00;
            lfsr          <= 8'h00;
            bit_idx       <= 3'd0;
            vote_cnt      <= 4'd0;
            ones          <= 4'd0;
            key           <= 8'h00;
            stable        <= 8'h00;
            puf_challenge <= 8'h00;
            puf_pulse     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state <= state_nxt;
            lfsr  <= lfsr_nxt;
            cnt   <= (state_nxt != state) ? 8'h00 : cnt + 8'd1;

            if (state == S_IDLE && start) begin
                bit_idx  <= 3'd0;
                vote_cnt <= 4'd0;
                ones     <= 4'd0;
                key      <= 8'h00;
                stable   <= 8'h00;
            end

            if (fire_last) begin
                ones     <= ones + {3'b000, puf_response};
                vote_cnt <= vote_cnt + 4'd1;
            end

            if (state == S_RESOLVE) begin
                key[bit_idx]    <= (ones > 4'(VOTES / 2));
                stable[bit_idx] <= (ones == 4'd0) || (ones == 4'(VOTES));
                ones            <= 4'd0;
                vote_cnt        <= 4'd0;
                bit_idx         <= bit_idx + 3'd1;
            end

            // Outputs are registered from the next state so they never glitch.
            puf_challenge <= chal_on_nxt ? lfsr_nxt : 8'h00;
            puf_pulse     <= (state_nxt == S_FIRE);
            busy          <= (state_nxt != S_IDLE);
            done          <= (state_nxt == S_DONE);
        end
    end

endmodule
